fetch_pc_sequencer: RTL and testbench



---
 rtl/fetch_pc_sequencer_if.sv | 33 +++
 rtl/fetch_pc_sequencer.sv | 72 +++++++
 tb/tb_fetch_pc_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_sequencer_if.sv
// fetch_pc_sequencer_if: control and status bundle between fetch sequencer, IMEM and branch predictor
interface fetch_pc_sequencer_if #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int COUNT_WIDTH = 16
);
  logic i_Stall;
  logic i_Pred_valid;
  logic i_Pred_isbranch;
  logic i_Pred_taken;
  logic [ADDRESS_WIDTH-1:0] i_Pred_target;
  logic i_Flush;
  logic [ADDRESS_WIDTH-1:0] i_Flush_pc;
  logic [ADDRESS_WIDTH-1:0] o_IMEM_address;
  logic o_IMEM_read;
  logic [ADDRESS_WIDTH-1:0] o_D_pc;
  logic o_D_valid;
  logic [ADDRESS_WIDTH-1:0] o_ALU_pc;
  logic o_ALU_isbranch;
  logic o_ALU_prediction;
  logic o_ALU_valid;
  logic [COUNT_WIDTH-1:0] o_Redirect_count;
  logic [COUNT_WIDTH-1:0] o_Flush_count;
  modport slave (
    input i_Stall, i_Pred_valid, i_Pred_isbranch, i_Pred_taken, i_Pred_target, i_Flush, i_Flush_pc,
    output o_IMEM_address, o_IMEM_read, o_D_pc, o_D_valid, o_ALU_pc, o_ALU_isbranch,
    output o_ALU_prediction, o_ALU_valid, o_Redirect_count, o_Flush_count
  );
  modport master (
    output i_Stall, i_Pred_valid, i_Pred_isbranch, i_Pred_taken, i_Pred_target, i_Flush, i_Flush_pc,
    input o_IMEM_address, o_IMEM_read, o_D_pc, o_D_valid, o_ALU_pc, o_ALU_isbranch,
    input o_ALU_prediction, o_ALU_valid, o_Redirect_count, o_Flush_count
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: fetch PC generator tracking D/E slots, with taken-branch redirect and flush
module fetch_pc_sequencer #(
  parameter int ADDRESS_WIDTH = 22,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter int COUNT_WIDTH = 16
) (
  input logic i_Clk,
  input logic i_Reset,
  fetch_pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
  state_t state_q;
  logic [ADDRESS_WIDTH-1:0] pc_q, d_pc_q, e_pc_q;
  logic d_valid_q, e_valid_q, e_br_q, e_pred_q, taken;
  logic [COUNT_WIDTH-1:0] redir_q, redir_d, flush_q, flush_d;
  assign taken = d_valid_q & bus.i_Pred_valid & bus.i_Pred_isbranch & bus.i_Pred_taken;
  assign redir_d = &redir_q ? redir_q : redir_q + 1'b1;
  assign flush_d = &flush_q ? flush_q : flush_q + 1'b1;
  // Leaving STALL only re-enables fetch; slots advance from the following RUN cycle
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      d_pc_q <= '0;
      e_pc_q <= '0;
      d_valid_q <= 1'b0;
      e_valid_q <= 1'b0;
      e_br_q <= 1'b0;
      e_pred_q <= 1'b0;
      redir_q <= '0;
      flush_q <= '0;
    end else if (bus.i_Flush) begin
      state_q <= RUN;
      pc_q <= bus.i_Flush_pc;
      d_valid_q <= 1'b0;
      e_valid_q <= 1'b0;
      flush_q <= flush_d;
    end else if (state_q == IDLE) begin
      state_q <= RUN;
    end else if (state_q == STALL) begin
      if (!bus.i_Stall) state_q <= RUN;
    end else if (bus.i_Stall) begin
      state_q <= STALL;
    end else if (taken) begin
      pc_q <= bus.i_Pred_target;
      e_pc_q <= d_pc_q;
      e_br_q <= 1'b1;
      e_pred_q <= 1'b1;
      e_valid_q <= 1'b1;
      d_valid_q <= 1'b0;
      redir_q <= redir_d;
    end else begin
      pc_q <= pc_q + 1'b1;
      d_pc_q <= pc_q;
      d_valid_q <= 1'b1;
      e_pc_q <= d_pc_q;
      e_br_q <= bus.i_Pred_isbranch & bus.i_Pred_valid;
      e_pred_q <= bus.i_Pred_taken & bus.i_Pred_valid & bus.i_Pred_isbranch;
      e_valid_q <= d_valid_q;
    end
  end
  assign bus.o_IMEM_address = pc_q;
  assign bus.o_IMEM_read = state_q == RUN;
  assign bus.o_D_pc = d_pc_q;
  assign bus.o_D_valid = d_valid_q;
  assign bus.o_ALU_pc = e_pc_q;
  assign bus.o_ALU_isbranch = e_br_q;
  assign bus.o_ALU_prediction = e_pred_q;
  assign bus.o_ALU_valid = e_valid_q;
  assign bus.o_Redirect_count = redir_q;
  assign bus.o_Flush_count = flush_q;
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer: directed scenario tests with hand-computed expectations
module tb_fetch_pc_sequencer;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  fetch_pc_sequencer_if #(.ADDRESS_WIDTH(22), .COUNT_WIDTH(16)) bus ();
  fetch_pc_sequencer #(.ADDRESS_WIDTH(22), .RESET_PC(22'h10), .COUNT_WIDTH(16)) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_Stall = 0;
    bus.i_Pred_valid = 0;
    bus.i_Pred_isbranch = 0;
    bus.i_Pred_taken = 0;
    bus.i_Pred_target = '0;
    bus.i_Flush = 0;
    bus.i_Flush_pc = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    step();
    step();
    checks++; if (bus.o_IMEM_address !== 22'h10) begin failures++; $display("FAIL reset_addr got=%h exp=%h", bus.o_IMEM_address, 22'h10); end
    checks++; if (bus.o_IMEM_read !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", bus.o_IMEM_read); end
    checks++; if ({bus.o_D_valid, bus.o_ALU_valid, bus.o_ALU_isbranch, bus.o_ALU_prediction} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.o_D_valid, bus.o_ALU_valid, bus.o_ALU_isbranch, bus.o_ALU_prediction}); end
    checks++; if ({bus.o_D_pc, bus.o_ALU_pc} !== 44'h0) begin failures++; $display("FAIL reset_pcs got=%h/%h exp=0/0", bus.o_D_pc, bus.o_ALU_pc); end
    checks++; if ({bus.o_Redirect_count, bus.o_Flush_count} !== 32'h0) begin failures++; $display("FAIL reset_counts got=%h/%h exp=0/0", bus.o_Redirect_count, bus.o_Flush_count); end
    rst = 0;
  endtask

  task automatic test_sequential();
    step();
    checks++; if ({bus.o_IMEM_read, bus.o_IMEM_address, bus.o_D_valid} !== {1'b1, 22'h10, 1'b0}) begin failures++; $display("FAIL seq_first got=%b/%h/%b exp=1/000010/0", bus.o_IMEM_read, bus.o_IMEM_address, bus.o_D_valid); end
    step();
    checks++; if ({bus.o_IMEM_address, bus.o_D_pc, bus.o_D_valid, bus.o_ALU_valid} !== {22'h11, 22'h10, 2'b10}) begin failures++; $display("FAIL seq_second got=%h/%h/%b/%b exp=000011/000010/1/0", bus.o_IMEM_address, bus.o_D_pc, bus.o_D_valid, bus.o_ALU_valid); end
    step();
    checks++; if ({bus.o_IMEM_address, bus.o_D_pc, bus.o_ALU_pc} !== {22'h12, 22'h11, 22'h10}) begin failures++; $display("FAIL seq_third got=%h/%h/%h exp=000012/000011/000010", bus.o_IMEM_address, bus.o_D_pc, bus.o_ALU_pc); end
    checks++; if ({bus.o_ALU_valid, bus.o_ALU_isbranch, bus.o_ALU_prediction} !== 3'b100) begin failures++; $display("FAIL seq_alu_flags got=%b exp=100", {bus.o_ALU_valid, bus.o_ALU_isbranch, bus.o_ALU_prediction}); end
  endtask

  task automatic test_taken();
    step();
    checks++; if (bus.o_D_pc !== 22'h12) begin failures++; $display("FAIL taken_setup got=%h exp=000012", bus.o_D_pc); end
    bus.i_Pred_valid = 1; bus.i_Pred_isbranch = 1; bus.i_Pred_taken = 1; bus.i_Pred_target = 22'h40;
    step();
    clear_inputs();
    checks++; if ({bus.o_IMEM_address, bus.o_D_valid} !== {22'h40, 1'b0}) begin failures++; $display("FAIL taken_redirect got=%h/%b exp=000040/0", bus.o_IMEM_address, bus.o_D_valid); end
    checks++; if ({bus.o_ALU_pc, bus.o_ALU_valid, bus.o_ALU_isbranch, bus.o_ALU_prediction} !== {22'h12, 3'b111}) begin failures++; $display("FAIL taken_alu got=%h/%b%b%b exp=000012/111", bus.o_ALU_pc, bus.o_ALU_valid, bus.o_ALU_isbranch, bus.o_ALU_prediction); end
    checks++; if (bus.o_Redirect_count !== 16'd1) begin failures++; $display("FAIL taken_count got=%0d exp=1", bus.o_Redirect_count); end
    step();
    checks++; if ({bus.o_IMEM_address, bus.o_D_pc, bus.o_D_valid, bus.o_ALU_valid} !== {22'h41, 22'h40, 2'b10}) begin failures++; $display("FAIL taken_resume got=%h/%h/%b/%b exp=000041/000040/1/0", bus.o_IMEM_address, bus.o_D_pc, bus.o_D_valid, bus.o_ALU_valid); end
  endtask

  task automatic test_nonbranch_unpredicted();
    bus.i_Pred_valid = 0; bus.i_Pred_isbranch = 1; bus.i_Pred_taken = 1; bus.i_Pred_target = 22'h77;
    step();
    clear_inputs();
    checks++; if ({bus.o_IMEM_address, bus.o_ALU_pc, bus.o_ALU_valid, bus.o_ALU_isbranch, bus.o_ALU_prediction} !== {22'h42, 22'h40, 3'b100}) begin failures++; $display("FAIL nopred got=%h/%h/%b%b%b exp=000042/000040/100", bus.o_IMEM_address, bus.o_ALU_pc, bus.o_ALU_valid, bus.o_ALU_isbranch, bus.o_ALU_prediction); end
    bus.i_Pred_valid = 1; bus.i_Pred_isbranch = 1; bus.i_Pred_taken = 0;
    step();
    clear_inputs();
    checks++; if ({bus.o_IMEM_address, bus.o_ALU_pc, bus.o_ALU_isbranch, bus.o_ALU_prediction} !== {22'h43, 22'h41, 2'b10}) begin failures++; $display("FAIL not_taken got=%h/%h/%b%b exp=000043/000041/10", bus.o_IMEM_address, bus.o_ALU_pc, bus.o_ALU_isbranch, bus.o_ALU_prediction); end
  endtask

  task automatic test_flush_vs_taken();
    bus.i_Flush = 1; bus.i_Flush_pc = 22'h80;
    bus.i_Pred_valid = 1; bus.i_Pred_isbranch = 1; bus.i_Pred_taken = 1; bus.i_Pred_target = 22'h40;
    step();
    clear_inputs();
    checks++; if ({bus.o_IMEM_address, bus.o_D_valid, bus.o_ALU_valid} !== {22'h80, 2'b00}) begin failures++; $display("FAIL flush_addr got=%h/%b/%b exp=000080/0/0", bus.o_IMEM_address, bus.o_D_valid, bus.o_ALU_valid); end
    checks++; if ({bus.o_Flush_count, bus.o_Redirect_count} !== {16'd1, 16'd1}) begin failures++; $display("FAIL flush_counts got=%0d/%0d exp=1/1", bus.o_Flush_count, bus.o_Redirect_count); end
  endtask

  task automatic test_stall();
    bus.i_Flush = 1; bus.i_Flush_pc = 22'h20;
    step();
    clear_inputs();
    step();
    step();
    checks++; if ({bus.o_IMEM_address, bus.o_D_pc, bus.o_ALU_pc} !== {22'h22, 22'h21, 22'h20}) begin failures++; $display("FAIL stall_setup got=%h/%h/%h exp=000022/000021/000020", bus.o_IMEM_address, bus.o_D_pc, bus.o_ALU_pc); end
    bus.i_Stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({bus.o_IMEM_read, bus.o_IMEM_address, bus.o_D_pc, bus.o_D_valid, bus.o_ALU_pc, bus.o_ALU_valid} !== {1'b0, 22'h22, 22'h21, 1'b1, 22'h20, 1'b1}) begin failures++; $display("FAIL stall_hold%0d got=%b/%h/%h/%h exp=0/000022/000021/000020", i, bus.o_IMEM_read, bus.o_IMEM_address, bus.o_D_pc, bus.o_ALU_pc); end
    end
    bus.i_Flush = 1; bus.i_Flush_pc = 22'h90;
    step();
    clear_inputs();
    checks++; if ({bus.o_IMEM_read, bus.o_IMEM_address, bus.o_D_valid} !== {1'b1, 22'h90, 1'b0}) begin failures++; $display("FAIL stall_flush got=%b/%h/%b exp=1/000090/0", bus.o_IMEM_read, bus.o_IMEM_address, bus.o_D_valid); end
    checks++; if (bus.o_Flush_count !== 16'd3) begin failures++; $display("FAIL stall_flush_count got=%0d exp=3", bus.o_Flush_count); end
    step();
    bus.i_Stall = 1;
    step();
    bus.i_Stall = 0;
    checks++; if ({bus.o_IMEM_read, bus.o_IMEM_address} !== {1'b0, 22'h91}) begin failures++; $display("FAIL stall_enter got=%b/%h exp=0/000091", bus.o_IMEM_read, bus.o_IMEM_address); end
    step();
    checks++; if ({bus.o_IMEM_read, bus.o_IMEM_address} !== {1'b1, 22'h91}) begin failures++; $display("FAIL stall_release got=%b/%h exp=1/000091", bus.o_IMEM_read, bus.o_IMEM_address); end
    step();
    checks++; if ({bus.o_IMEM_address, bus.o_D_pc} !== {22'h92, 22'h91}) begin failures++; $display("FAIL stall_resume got=%h/%h exp=000092/000091", bus.o_IMEM_address, bus.o_D_pc); end
  endtask

  task automatic test_wrap();
    bus.i_Flush = 1; bus.i_Flush_pc = 22'h3FFFFF;
    step();
    clear_inputs();
    checks++; if (bus.o_IMEM_address !== 22'h3FFFFF) begin failures++; $display("FAIL wrap_preset got=%h exp=3fffff", bus.o_IMEM_address); end
    step();
    checks++; if ({bus.o_IMEM_address, bus.o_D_pc, bus.o_D_valid} !== {22'h0, 22'h3FFFFF, 1'b1}) begin failures++; $display("FAIL wrap_next got=%h/%h/%b exp=000000/3fffff/1", bus.o_IMEM_address, bus.o_D_pc, bus.o_D_valid); end
  endtask

  task automatic test_reset_mid();
    bus.i_Pred_valid = 1; bus.i_Pred_isbranch = 1; bus.i_Pred_taken = 1; bus.i_Pred_target = 22'h55;
    rst = 1;
    step();
    rst = 0;
    clear_inputs();
    checks++; if ({bus.o_IMEM_address, bus.o_IMEM_read, bus.o_D_valid, bus.o_ALU_valid} !== {22'h10, 3'b000}) begin failures++; $display("FAIL rstmid_state got=%h/%b/%b/%b exp=000010/0/0/0", bus.o_IMEM_address, bus.o_IMEM_read, bus.o_D_valid, bus.o_ALU_valid); end
    checks++; if ({bus.o_Redirect_count, bus.o_Flush_count} !== 32'h0) begin failures++; $display("FAIL rstmid_counts got=%0d/%0d exp=0/0", bus.o_Redirect_count, bus.o_Flush_count); end
    step();
    checks++; if ({bus.o_IMEM_read, bus.o_IMEM_address} !== {1'b1, 22'h10}) begin failures++; $display("FAIL rstmid_resume got=%b/%h exp=1/000010", bus.o_IMEM_read, bus.o_IMEM_address); end
    step();
    checks++; if ({bus.o_IMEM_address, bus.o_D_pc, bus.o_D_valid} !== {22'h11, 22'h10, 1'b1}) begin failures++; $display("FAIL rstmid_seq got=%h/%h/%b exp=000011/000010/1", bus.o_IMEM_address, bus.o_D_pc, bus.o_D_valid); end
  endtask

  task automatic test_saturation();
    bus.i_Flush = 1; bus.i_Flush_pc = 22'h5;
    for (int i = 0; i < 65534; i++) step();
    checks++; if (bus.o_Flush_count !== 16'hFFFE) begin failures++; $display("FAIL sat_below got=%h exp=fffe", bus.o_Flush_count); end
    step();
    checks++; if (bus.o_Flush_count !== 16'hFFFF) begin failures++; $display("FAIL sat_max got=%h exp=ffff", bus.o_Flush_count); end
    step();
    step();
    clear_inputs();
    checks++; if (bus.o_Flush_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", bus.o_Flush_count); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_taken();
    test_nonbranch_unpredicted();
    test_flush_vs_taken();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
